// File: rtl/axi_rd_arb_pkg.sv
// Shared types and constants for the AXI read-channel arbiter and its helpers.
package axi_rd_arb_pkg;

  localparam int ARB_MAX_N = 16;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_SIZE_1B    = 2'b00;

  typedef enum logic {
    IDLE,
    ISSUE
  } arb_state_t;

endpackage

// File: rtl/axi_rd_arbiter_rr_pick.sv
// Round-robin priority encoder: first set bit of mask at or after ptr, wrapping.
// Purely combinational, no backpressure; reusable for write-channel arbitration.
module rr_pick
  import axi_rd_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] mask,
  input  logic [3:0]   ptr,
  output logic [3:0]   grant,
  output logic         any
);

  logic [ARB_MAX_N-1:0] mask_x;
  logic [3:0]           idx;

  // Walk from the farthest candidate back to ptr so the nearest one wins.
  always_comb begin
    mask_x = ARB_MAX_N'(mask);
    grant  = '0;
    any    = 1'b0;
    idx    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = 4'((int'(ptr) + k) % N);
      if (mask_x[idx]) begin
        grant = idx;
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Round-robin AR issue (1 cycle cmd->AR, AR held until arready) with combinational R steering by rid;
// R backpressure comes from the owning requester. AXI_RD_ARB_RESP_ERR_EN adds the sticky rsp_err output.
module axi_rd_arbiter
  import axi_rd_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic [N-1:0]    req_valid,
  output logic [N-1:0]    req_ready,
  input  logic [N*16-1:0] req_addr,
  input  logic [N*8-1:0]  req_len,
  output logic [N-1:0]    rsp_valid,
  input  logic [N-1:0]    rsp_ready,
  output logic [7:0]      rsp_data,
  output logic            rsp_last,
  output logic            err_unexp_id,
`ifdef AXI_RD_ARB_RESP_ERR_EN
  output logic [N-1:0]    rsp_err,
`endif
  output logic            axi_arvalid,
  input  logic            axi_arready,
  output logic [3:0]      axi_arid,
  output logic [15:0]     axi_araddr,
  output logic [7:0]      axi_arlen,
  output logic [1:0]      axi_arsize,
  output logic [1:0]      axi_arburst,
  output logic [1:0]      axi_arlock,
  output logic [3:0]      axi_arcache,
  output logic [2:0]      axi_arprot,
  output logic [3:0]      axi_arqos,
  input  logic            axi_rvalid,
  output logic            axi_rready,
  input  logic [3:0]      axi_rid,
  input  logic [7:0]      axi_rdata,
  input  logic [1:0]      axi_rresp,
  input  logic            axi_rlast
);

  arb_state_t state, state_nxt;
  logic [N-1:0]  busy;
  logic [3:0]    ptr;
  logic [3:0]    pick_idx;
  logic          pick_any;
  logic          load, ar_done;
  logic [N-1:0]  pick_oh, set_mask, clr_mask;
  logic [15:0]   addr_a [ARB_MAX_N];
  logic [7:0]    len_a  [ARB_MAX_N];
  logic [ARB_MAX_N-1:0] busy_x, rdy_x;
  logic          rid_ok, rid_hit, r_last_hs;

  rr_pick #(.N(N)) u_pick (
    .mask  (req_valid & ~busy),
    .ptr   (ptr),
    .grant (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    for (int i = 0; i < ARB_MAX_N; i++) begin
      addr_a[i] = '0;
      len_a[i]  = '0;
    end
    for (int i = 0; i < N; i++) begin
      addr_a[i] = req_addr[i*16 +: 16];
      len_a[i]  = req_len[i*8 +: 8];
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    ar_done   = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          load      = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (axi_arvalid && axi_arready) begin
          ar_done   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy_x    = ARB_MAX_N'(busy);
  assign rdy_x     = ARB_MAX_N'(rsp_ready);
  assign rid_ok    = ({1'b0, axi_rid} < 5'(N));
  assign rid_hit   = busy_x[axi_rid];
  // Beats with no owner are drained so a stray response cannot wedge the channel.
  assign axi_rready = rid_ok ? (rid_hit ? rdy_x[axi_rid] : axi_rvalid) : 1'b1;
  assign r_last_hs = axi_rvalid & axi_rready & rid_hit & axi_rlast;
  assign rsp_data  = axi_rdata;
  assign rsp_last  = axi_rlast;

  always_comb begin
    pick_oh   = '0;
    set_mask  = '0;
    clr_mask  = '0;
    rsp_valid = '0;
    for (int i = 0; i < N; i++) begin
      pick_oh[i]   = (pick_idx == 4'(i));
      set_mask[i]  = ar_done & (axi_arid == 4'(i));
      clr_mask[i]  = r_last_hs & (axi_rid == 4'(i));
      rsp_valid[i] = axi_rvalid & (axi_rid == 4'(i)) & busy[i];
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      axi_arvalid  <= 1'b0;
      axi_arid     <= '0;
      axi_araddr   <= '0;
      axi_arlen    <= '0;
      req_ready    <= '0;
      busy         <= '0;
      ptr          <= '0;
      err_unexp_id <= 1'b0;
    end else begin
      req_ready <= '0;
      if (load) begin
        axi_arvalid <= 1'b1;
        axi_arid    <= pick_idx;
        axi_araddr  <= addr_a[pick_idx];
        axi_arlen   <= len_a[pick_idx];
        req_ready   <= pick_oh;
      end else if (ar_done) begin
        axi_arvalid <= 1'b0;
        ptr         <= (axi_arid == 4'(N - 1)) ? 4'd0 : axi_arid + 4'd1;
      end
      // A grant never targets a busy requester, so set and clear bits never collide.
      busy <= (busy | set_mask) & ~clr_mask;
      if (axi_rvalid && !rid_hit) err_unexp_id <= 1'b1;
    end
  end

`ifdef AXI_RD_ARB_RESP_ERR_EN
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rsp_err <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (axi_rvalid && axi_rready && rid_hit && (axi_rid == 4'(i)) && (axi_rresp != 2'b00))
          rsp_err[i] <= 1'b1;
      end
    end
  end
`else
  logic unused_rresp;
  assign unused_rresp = ^axi_rresp;
`endif

  assign axi_arsize  = AXI_SIZE_1B;
  assign axi_arburst = AXI_BURST_INCR;
  assign axi_arlock  = 2'b00;
  assign axi_arcache = 4'b0000;
  assign axi_arprot  = 3'b000;
  assign axi_arqos   = 4'b0000;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_axi_rd_arbiter;

  localparam int N = 4;

  logic            clk;
  logic            nreset;
  logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*16-1:0] req_addr;
  logic [N*8-1:0]  req_len;
  logic [7:0]      rsp_data;
  logic            rsp_last, err_unexp_id;
`ifdef AXI_RD_ARB_RESP_ERR_EN
  logic [N-1:0]    rsp_err;
`endif
  logic            axi_arvalid, axi_arready;
  logic [3:0]      axi_arid;
  logic [15:0]     axi_araddr;
  logic [7:0]      axi_arlen;
  logic [1:0]      axi_arsize, axi_arburst, axi_arlock;
  logic [3:0]      axi_arcache, axi_arqos;
  logic [2:0]      axi_arprot;
  logic            axi_rvalid, axi_rready, axi_rlast;
  logic [3:0]      axi_rid;
  logic [7:0]      axi_rdata;
  logic [1:0]      axi_rresp;

  int errors = 0;
  int checks = 0;

  axi_rd_arbiter #(.N(N)) dut (
    .clk(clk), .nreset(nreset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .err_unexp_id(err_unexp_id),
`ifdef AXI_RD_ARB_RESP_ERR_EN
    .rsp_err(rsp_err),
`endif
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_arid(axi_arid),
    .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
    .axi_arburst(axi_arburst), .axi_arlock(axi_arlock), .axi_arcache(axi_arcache),
    .axi_arprot(axi_arprot), .axi_arqos(axi_arqos),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rid(axi_rid),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time %0t required below 1000000", $time);
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = '0; req_addr = '0; req_len = '0; rsp_ready = '0;
    axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rid = '0; axi_rdata = '0;
    axi_rresp = '0; axi_rlast = 1'b0;
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1 nreset = 1'b1;
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    idle_inputs();
    @(negedge clk);
    checks++; if (axi_arvalid !== 1'b0) begin errors++; $display("FAIL reset_arvalid: got %b want 0", axi_arvalid); end
    checks++; if (axi_arid !== 4'h0) begin errors++; $display("FAIL reset_arid: got %h want 0", axi_arid); end
    checks++; if (axi_araddr !== 16'h0) begin errors++; $display("FAIL reset_araddr: got %h want 0", axi_araddr); end
    checks++; if (axi_arlen !== 8'h0) begin errors++; $display("FAIL reset_arlen: got %h want 0", axi_arlen); end
    checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
    checks++; if (rsp_valid !== 4'h0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (axi_rready !== 1'b0) begin errors++; $display("FAIL reset_rready: got %b want 0", axi_rready); end
    checks++; if (err_unexp_id !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_unexp_id); end
    checks++; if ({axi_arsize, axi_arburst, axi_arlock, axi_arcache, axi_arprot, axi_arqos} !== {2'b00, 2'b01, 2'b00, 4'h0, 3'h0, 4'h0})
      begin errors++; $display("FAIL ar_const: got %b/%b/%b/%h/%h/%h want 0/01/0/0/0/0", axi_arsize, axi_arburst, axi_arlock, axi_arcache, axi_arprot, axi_arqos); end
    cyc();
    nreset = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0100; req_addr[2*16 +: 16] = 16'h1234; req_len[2*8 +: 8] = 8'd3; axi_arready = 1'b1;
    @(negedge clk);
    checks++; if (axi_arvalid !== 1'b0) begin errors++; $display("FAIL single_ar_early: got %b want 0", axi_arvalid); end
    cyc();
    @(negedge clk);
    checks++; if ({axi_arvalid, axi_arid, axi_araddr, axi_arlen} !== {1'b1, 4'd2, 16'h1234, 8'd3})
      begin errors++; $display("FAIL single_ar: got v%b id%h a%h l%h want v1 id2 a1234 l03", axi_arvalid, axi_arid, axi_araddr, axi_arlen); end
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_req_ready: got %b want 0100", req_ready); end
    cyc();
    req_valid = '0;
    @(negedge clk);
    checks++; if ({axi_arvalid, req_ready} !== 5'b0) begin errors++; $display("FAIL single_ar_drop: got v%b rr%b want 0 0000", axi_arvalid, req_ready); end
    for (int b = 0; b < 4; b++) begin
      axi_rvalid = 1'b1; axi_rid = 4'd2; axi_rdata = 8'(8'hA0 + b); axi_rlast = (b == 3); rsp_ready = 4'b0100;
      @(negedge clk);
      checks++; if ({rsp_valid, axi_rready, rsp_last, rsp_data} !== {4'b0100, 1'b1, (b == 3), 8'(8'hA0 + b)})
        begin errors++; $display("FAIL single_beat%0d: got v%b rdy%b last%b d%h", b, rsp_valid, axi_rready, rsp_last, rsp_data); end
      cyc();
    end
    axi_rvalid = 1'b0; axi_rlast = 1'b0;
    req_valid = 4'b0100; req_addr[2*16 +: 16] = 16'h0042; req_len[2*8 +: 8] = 8'd0;
    cyc();
    @(negedge clk);
    checks++; if ({axi_arvalid, axi_arid, axi_araddr} !== {1'b1, 4'd2, 16'h0042})
      begin errors++; $display("FAIL single_busy_clear: got v%b id%h a%h want v1 id2 a0042", axi_arvalid, axi_arid, axi_araddr); end
    checks++; if (err_unexp_id !== 1'b0) begin errors++; $display("FAIL single_err: got %b want 0", err_unexp_id); end
  endtask

  task automatic test_round_robin();
    int ids[$];
    logic [N-1:0] granted;
    do_reset();
    granted = '0;
    for (int i = 0; i < N; i++) req_addr[i*16 +: 16] = 16'(i * 16'h100);
    req_valid = 4'hF; axi_arready = 1'b1;
    for (int c = 0; c < 40 && ids.size() < 4; c++) begin
      @(negedge clk);
      checks++; if ((req_ready & granted) !== 4'h0) begin errors++; $display("FAIL rr_regrant_busy: got %b granted %b want no overlap", req_ready, granted); end
      if (axi_arvalid && axi_arready) begin
        ids.push_back(int'(axi_arid));
        granted[axi_arid[1:0]] = 1'b1;
      end
      cyc();
    end
    checks++; if (ids.size() != 4) begin errors++; $display("FAIL rr_timeout: got %0d issues want 4", ids.size()); end
    for (int i = 0; i < ids.size(); i++) begin
      checks++; if (ids[i] != i) begin errors++; $display("FAIL rr_order%0d: got id %0d want %0d", i, ids[i], i); end
    end
    repeat (5) begin
      @(negedge clk);
      checks++; if (axi_arvalid !== 1'b0) begin errors++; $display("FAIL rr_all_busy: got arvalid %b want 0", axi_arvalid); end
      cyc();
    end
    rsp_ready = 4'hF;
    for (int i = 0; i < N; i++) begin
      axi_rvalid = 1'b1; axi_rid = 4'(i); axi_rlast = 1'b1; axi_rdata = 8'(i);
      @(negedge clk);
      checks++; if (rsp_valid !== 4'(1 << i)) begin errors++; $display("FAIL rr_resp%0d: got %b want %b", i, rsp_valid, 4'(1 << i)); end
      cyc();
    end
    axi_rvalid = 1'b0; req_valid = '0;
  endtask

  task automatic test_stall();
    logic [15:0] a0;
    logic [7:0]  l0;
    do_reset();
    a0 = 16'($urandom); l0 = 8'($urandom);
    req_addr = {16'($urandom), 16'($urandom), 16'($urandom), a0};
    req_len  = {8'($urandom), 8'($urandom), 8'($urandom), l0};
    req_valid = 4'b1011; axi_arready = 1'b0;
    cyc();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++; if ({axi_arvalid, axi_arid, axi_araddr, axi_arlen} !== {1'b1, 4'd0, a0, l0})
        begin errors++; $display("FAIL stall_hold%0d: got v%b id%h a%h l%h want v1 id0 a%h l%h", c, axi_arvalid, axi_arid, axi_araddr, axi_arlen, a0, l0); end
      checks++; if (req_ready !== ((c == 0) ? 4'b0001 : 4'b0000)) begin errors++; $display("FAIL stall_req_ready%0d: got %b", c, req_ready); end
      req_addr[15:0] = 16'($urandom);
      cyc();
    end
    axi_arready = 1'b1;
    cyc();
    @(negedge clk);
    checks++; if (axi_arvalid !== 1'b0) begin errors++; $display("FAIL stall_release: got %b want 0", axi_arvalid); end
    cyc();
    @(negedge clk);
    checks++; if ({axi_arvalid, axi_arid} !== {1'b1, 4'd1}) begin errors++; $display("FAIL stall_next: got v%b id%h want v1 id1", axi_arvalid, axi_arid); end
    cyc(); cyc();
    @(negedge clk);
    checks++; if ({axi_arvalid, axi_arid} !== {1'b1, 4'd3}) begin errors++; $display("FAIL stall_skip2: got v%b id%h want v1 id3", axi_arvalid, axi_arid); end
  endtask

  task automatic test_out_of_order();
    do_reset();
    req_valid = 4'b1010; req_len = {8'd1, 8'd0, 8'd1, 8'd0}; axi_arready = 1'b1;
    repeat (5) cyc();
    req_valid = '0;
    axi_rvalid = 1'b1; axi_rid = 4'd3; axi_rdata = 8'h5A; axi_rlast = 1'b0; rsp_ready = 4'b0010;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if ({axi_rready, rsp_valid} !== {1'b0, 4'b1000}) begin errors++; $display("FAIL ooo_stall%0d: got rdy%b v%b want 0 1000", c, axi_rready, rsp_valid); end
      cyc();
    end
    rsp_ready = 4'b1010;
    for (int b = 0; b < 2; b++) begin
      axi_rdata = 8'(8'h5A + b); axi_rlast = (b == 1);
      @(negedge clk);
      checks++; if ({axi_rready, rsp_valid, rsp_data} !== {1'b1, 4'b1000, 8'(8'h5A + b)})
        begin errors++; $display("FAIL ooo_id3_beat%0d: got rdy%b v%b d%h", b, axi_rready, rsp_valid, rsp_data); end
      cyc();
    end
    axi_rid = 4'd1; axi_rdata = 8'h11; axi_rlast = 1'b0;
    @(negedge clk);
    checks++; if ({axi_rready, rsp_valid} !== {1'b1, 4'b0010}) begin errors++; $display("FAIL ooo_id1: got rdy%b v%b want 1 0010", axi_rready, rsp_valid); end
    checks++; if (err_unexp_id !== 1'b0) begin errors++; $display("FAIL ooo_err: got %b want 0", err_unexp_id); end
    axi_rvalid = 1'b0;
  endtask

  task automatic test_unexp_id();
    do_reset();
    axi_rvalid = 1'b1; axi_rid = 4'd7; axi_rdata = 8'hEE; axi_rlast = 1'b1;
    @(negedge clk);
    checks++; if ({axi_rready, rsp_valid} !== {1'b1, 4'b0000}) begin errors++; $display("FAIL unexp_accept: got rdy%b v%b want 1 0000", axi_rready, rsp_valid); end
    cyc();
    axi_rvalid = 1'b0;
    @(negedge clk);
    checks++; if (err_unexp_id !== 1'b1) begin errors++; $display("FAIL unexp_flag: got %b want 1", err_unexp_id); end
    repeat (3) cyc();
    @(negedge clk);
    checks++; if (err_unexp_id !== 1'b1) begin errors++; $display("FAIL unexp_sticky: got %b want 1", err_unexp_id); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_valid = 4'b0001; req_addr[15:0] = 16'hBEEF; req_len[7:0] = 8'd7; axi_arready = 1'b1;
    repeat (3) cyc();
    req_valid = '0;
    axi_rvalid = 1'b1; axi_rid = 4'd9; axi_rlast = 1'b0;
    cyc();
    axi_rid = 4'd0; rsp_ready = 4'b0001;
    @(negedge clk);
    checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL mid_beat: got %b want 0001", rsp_valid); end
    nreset = 1'b0; axi_rvalid = 1'b0;
    #1;
    checks++; if ({axi_arvalid, axi_arid, axi_araddr, axi_arlen, req_ready, rsp_valid, axi_rready, err_unexp_id} !== 36'h0)
      begin errors++; $display("FAIL mid_reset: got v%b id%h a%h l%h rr%b rv%b rdy%b err%b want all 0", axi_arvalid, axi_arid, axi_araddr, axi_arlen, req_ready, rsp_valid, axi_rready, err_unexp_id); end
    cyc();
    nreset = 1'b1; axi_rvalid = 1'b1; axi_rid = 4'd0;
    @(negedge clk);
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL mid_busy_dropped: got %b want 0000", rsp_valid); end
    cyc();
    axi_rvalid = 1'b0;
  endtask

`ifdef AXI_RD_ARB_RESP_ERR_EN
  task automatic test_resp_err();
    do_reset();
    req_valid = 4'b0010; axi_arready = 1'b1;
    repeat (3) cyc();
    req_valid = '0;
    axi_rvalid = 1'b1; axi_rid = 4'd1; axi_rdata = 8'h77; axi_rresp = 2'b10; axi_rlast = 1'b1; rsp_ready = 4'b0010;
    @(negedge clk);
    checks++; if ({rsp_valid, rsp_data} !== {4'b0010, 8'h77}) begin errors++; $display("FAIL resp_err_deliver: got v%b d%h want 0010 77", rsp_valid, rsp_data); end
    cyc();
    axi_rvalid = 1'b0; axi_rresp = 2'b00;
    @(negedge clk);
    checks++; if (rsp_err !== 4'b0010) begin errors++; $display("FAIL resp_err_flag: got %b want 0010", rsp_err); end
  endtask
`endif

  task automatic test_random();
    bit          m_pend, m_err;
    int          m_id, m_ptr, j;
    logic [15:0] m_addr;
    logic [7:0]  m_len;
    logic [N-1:0] m_rr, m_busy, new_busy, exp_rv;
    bit          exp_rdy, ar_hs, r_hs, owned;
    bit          seen [N];
    int          q_id[$], q_len[$];
    bit          s_act;
    int          s_sel, s_beat;
    logic [7:0]  s_data;
    do_reset();
    m_pend = 0; m_err = 0; m_id = 0; m_ptr = 0; m_addr = '0; m_len = '0; m_rr = '0; m_busy = '0;
    s_act = 0; s_sel = 0; s_beat = 0; s_data = '0;
    for (int i = 0; i < N; i++) seen[i] = 0;
    for (int cyc_n = 0; cyc_n < 3000; cyc_n++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(2) == 0) begin
            req_valid[i] = 1'b1; req_addr[i*16 +: 16] = 16'($urandom); req_len[i*8 +: 8] = 8'($urandom_range(3)); seen[i] = 0;
          end
        end else if (seen[i] && $urandom_range(1) == 0) begin
          req_valid[i] = 1'b0; seen[i] = 0;
        end
      end
      axi_arready = ($urandom_range(1) == 1);
      rsp_ready = 4'($urandom);
      if (!s_act && q_id.size() > 0 && $urandom_range(2) != 0) begin
        s_act = 1; s_sel = $urandom_range(q_id.size() - 1); s_beat = 0; s_data = 8'($urandom);
      end
      axi_rvalid = s_act; axi_rid = s_act ? 4'(q_id[s_sel]) : 4'($urandom_range(3));
      axi_rdata = s_data; axi_rlast = s_act && (s_beat == q_len[s_sel]);

      @(negedge clk);
      owned = (int'(axi_rid) < N) && m_busy[axi_rid[1:0]];
      exp_rv = '0;
      if (axi_rvalid && owned) exp_rv[axi_rid[1:0]] = 1'b1;
      exp_rdy = (int'(axi_rid) >= N) ? 1'b1 : (owned ? rsp_ready[axi_rid[1:0]] : axi_rvalid);
      checks++; if (axi_arvalid !== m_pend) begin errors++; $display("FAIL rnd_arvalid c%0d: got %b want %b", cyc_n, axi_arvalid, m_pend); end
      if (m_pend) begin
        checks++; if ({axi_arid, axi_araddr, axi_arlen} !== {4'(m_id), m_addr, m_len})
          begin errors++; $display("FAIL rnd_ar c%0d: got id%h a%h l%h want id%h a%h l%h", cyc_n, axi_arid, axi_araddr, axi_arlen, m_id, m_addr, m_len); end
      end
      checks++; if (req_ready !== m_rr) begin errors++; $display("FAIL rnd_req_ready c%0d: got %b want %b", cyc_n, req_ready, m_rr); end
      checks++; if ({rsp_valid, axi_rready} !== {exp_rv, exp_rdy}) begin errors++; $display("FAIL rnd_r c%0d: got v%b rdy%b want v%b rdy%b", cyc_n, rsp_valid, axi_rready, exp_rv, exp_rdy); end
      if (axi_rvalid) begin
        checks++; if ({rsp_data, rsp_last} !== {axi_rdata, axi_rlast}) begin errors++; $display("FAIL rnd_data c%0d: got d%h l%b want d%h l%b", cyc_n, rsp_data, rsp_last, axi_rdata, axi_rlast); end
      end
      checks++; if (err_unexp_id !== m_err) begin errors++; $display("FAIL rnd_err c%0d: got %b want %b", cyc_n, err_unexp_id, m_err); end

      for (int i = 0; i < N; i++) if (m_rr[i]) seen[i] = 1;
      ar_hs = m_pend && axi_arready;
      r_hs  = axi_rvalid && exp_rdy;
      new_busy = m_busy;
      if (r_hs && owned && axi_rlast) new_busy[axi_rid[1:0]] = 1'b0;
      if (axi_rvalid && !owned) m_err = 1;
      if (m_pend) begin
        m_rr = '0;
        if (ar_hs) begin
          new_busy[m_id] = 1'b1; m_ptr = (m_id + 1) % N; m_pend = 0;
          q_id.push_back(m_id); q_len.push_back(int'(m_len));
        end
      end else begin
        for (int k = 0; k < N; k++) begin
          j = (m_ptr + k) % N;
          if (!m_pend && req_valid[j] && !m_busy[j]) begin
            m_pend = 1; m_id = j; m_addr = req_addr[j*16 +: 16]; m_len = req_len[j*8 +: 8]; m_rr = 4'(1 << j);
          end
        end
      end
      m_busy = new_busy;
      if (s_act && r_hs) begin
        if (s_beat == q_len[s_sel]) begin
          q_id.delete(s_sel); q_len.delete(s_sel); s_act = 0;
        end else begin
          s_beat++; s_data = 8'($urandom);
        end
      end
      cyc();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_out_of_order();
    test_unexp_id();
    test_reset_mid();
`ifdef AXI_RD_ARB_RESP_ERR_EN
    test_resp_err();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter.md
# axi_rd_arbiter

Shares the single AXI read channel (16-bit address, 8-bit data, 4-bit ID) between up to 16 DMA-style requesters. Requesters issue burst read commands. The arbiter selects one per issue slot round-robin and tags the AR ID with the requester index. It steers R beats back to the owning requester by `rid`. It sits between the per-engine read clients and the system AXI interconnect.

## Interface
Parameters:
- `N`, default 4 — number of requesters, 1..16. Requester index is used directly as the AXI ID.

Ports (clock and reset first):
- `clk` input 1 — the single clock; all logic is on the rising edge.
- `nreset` input 1 — reset, asynchronous and active-low.
- `req_valid` input N — per-requester command valid.
- `req_ready` output N — per-requester command accepted.
- `req_addr` input N*16 — start byte address; slice i belongs to requester i.
- `req_len` input N*8 — beats minus one, in AXI `arlen` encoding.
- `rsp_valid` output N — beat valid for requester i.
- `rsp_ready` input N — requester i accepts the beat.
- `rsp_data` output 8 — beat data, shared by all requesters.
- `rsp_last` output 1 — last beat of the burst, shared.
- `err_unexp_id` output 1 — sticky flag: an R beat arrived with an ID that has no outstanding burst.
- AXI AR master signals: `axi_arvalid` output 1, `axi_arready` input 1, `axi_arid` output 4, `axi_araddr` output 16, `axi_arlen` output 8, `axi_arsize` output 2, `axi_arburst` output 2, `axi_arlock` output 2, `axi_arcache` output 4, `axi_arprot` output 3, `axi_arqos` output 4.
- AXI R slave signals: `axi_rvalid` input 1, `axi_rready` output 1, `axi_rid` input 4, `axi_rdata` input 8, `axi_rresp` input 2, `axi_rlast` input 1.

## Operation
- `busy[N]` register: bit i is set when requester i's AR handshake completes and cleared on its R beat handshake with `axi_rlast`=1. At most one burst is outstanding per requester, so up to N are outstanding in total.
- Eligible requesters: `req_valid[i] & ~busy[i]`.
- Arbiter FSM, two states:
  - IDLE: if any requester is eligible, grant the first eligible index at or after `ptr` (round-robin). Latch its addr/len into the AR registers, set `axi_arvalid`=1, pulse `req_ready[i]`=1 for this single cycle, and go to ISSUE.
  - ISSUE: hold all AR fields stable until `axi_arvalid & axi_arready`. On the handshake, set `busy[grant]`, set `ptr` = grant+1 mod N, drop `axi_arvalid`, and return to IDLE.
- Constant AR fields: `axi_arsize`=0 (1 byte), `axi_arburst`=2'b01 (INCR), `axi_arlock`=0, `axi_arcache`=0, `axi_arprot`=0, `axi_arqos`=0. `axi_arid` = zero-extended grant index.
- R steering is combinational, with no buffering:
  - `rsp_valid[i]` = `axi_rvalid & (axi_rid==i) & busy[i]`.
  - `rsp_data` = `axi_rdata`; `rsp_last` = `axi_rlast`.
  - `axi_rready` = `rsp_ready[axi_rid] & busy[axi_rid]` when the ID is valid.
- An R beat with `axi_rid`>=N or `~busy[rid]` is accepted (`axi_rready`=1) and discarded, and it sets `err_unexp_id`. Only reset clears the flag.
- `axi_rresp` is ignored in the base build.
- The AR handshake for requester i and the last beat of requester i's previous burst cannot coincide, because busy requesters are never granted. If a last beat for j and an AR handshake for k≠j happen in the same cycle, both busy updates apply.

## Timing
- Reset values: `axi_arvalid`=0, `axi_arid`=0, `axi_araddr`=0, `axi_arlen`=0, `req_ready`=0, `busy`=0, `ptr`=0, `err_unexp_id`=0, FSM=IDLE. Combinational outputs follow from `busy`=0, so `rsp_valid`=0 and `axi_rready`=0 for valid IDs.
- Latency: `req_valid` seen in IDLE gives `axi_arvalid` high on the next edge, so command to AR is 1 cycle. The minimum spacing between AR issues is 2 cycles.
- `req_ready` is a registered 1-cycle pulse. The requester must hold addr/len valid up to and including that cycle.
- R path: zero-cycle combinational pass-through.
- Reset assertion mid-burst drops all state immediately. The surrounding system resets the interconnect concurrently.

## Configuration
- `AXI_RD_ARB_RESP_ERR_EN`:
  - Defined: a beat with `axi_rresp`!=0 (SLVERR/DECERR) is still delivered. A sticky N-bit output `rsp_err` gets bit rid set. `rsp_err` resets to 0.
  - Undefined: the `rsp_err` port does not exist and `axi_rresp` is unused.

## Structure
- Package `axi_rd_arb_pkg`:
  - constants `AXI_BURST_INCR`=2'b01, `AXI_SIZE_1B`=2'b00;
  - enum `arb_state_t` {IDLE, ISSUE};
  - max requester count `ARB_MAX_N`=16.
- One sub-module, `rr_pick`: combinational round-robin priority encoder that maps (eligible mask, ptr) to (grant index, any). It is also reusable by write-channel arbitration.

## Test plan
- N=4, only requester 2 requests addr 0x1234 len 3, `axi_arready` tied high → AR issued with id=2, addr=0x1234, arlen=3 one cycle later. 4 beats arrive on `rsp_valid[2]`, `rsp_last` on beat 4, and `busy[2]` clears.
- All 4 requesters request continuously; slave returns bursts in order → AR IDs issue 0,1,2,3, and no requester is re-granted while busy.
- `axi_arready` held low for 20 cycles → `axi_arvalid`, id, addr and len stay stable for all 20 cycles, and nothing else is granted.
- Out-of-order R: bursts for ids 1 and 3 outstanding, slave returns id 3 first; `rsp_ready[3]`=0 for 5 cycles → `axi_rready`=0 during those cycles, and data reaches only requester 3.
- R beat with rid=7 and N=4 → accepted, dropped, `err_unexp_id`=1 and it stays set. `nreset` pulse mid-burst → all outputs return to their reset values.
- With `AXI_RD_ARB_RESP_ERR_EN` defined: beat with rresp=2'b10 on id 1 → `rsp_err`=4'b0010 and the data is still delivered.
